// File: rtl/modsq_iter_sequencer.sv
// Job-level sequencer for the modular squaring wrapper. It takes one {initial value, T} job,
// drives the squarer through reset/load/start, counts T completions and returns the result.
module modsq_iter_sequencer #(
    parameter int MOD_LEN      = 1024,
    parameter int WORD_LEN     = 16,
    parameter int NUM_ELEMENTS = MOD_LEN / WORD_LEN + 2,
    parameter int SQ_OUT_BITS  = NUM_ELEMENTS * 32,
    parameter int ITER_W       = 32,
    parameter int RST_CYCLES   = 8,
    parameter int SETUP_CYCLES = 4,
    parameter int TIMEOUT      = 4096
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   job_valid,
    output logic                   job_ready,
    input  logic [MOD_LEN-1:0]     job_sq_in,
    input  logic [ITER_W-1:0]      job_iters,
    input  logic                   abort,
    output logic                   sq_reset,
    output logic                   sq_start,
    output logic [MOD_LEN-1:0]     sq_in,
    input  logic [SQ_OUT_BITS-1:0] sq_out,
    input  logic                   sq_valid,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [SQ_OUT_BITS-1:0] res_sq_out,
    output logic [ITER_W-1:0]      res_iters_done,
    output logic                   res_timeout,
    output logic                   busy
);

    localparam int PH_MAX = (RST_CYCLES > SETUP_CYCLES) ? RST_CYCLES : SETUP_CYCLES;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam int WD_W   = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        SQRST,
        LOAD,
        START,
        RUN,
        DONE
    } state_t;

    state_t                 state;
    logic [PH_W-1:0]        phase;
    logic [WD_W-1:0]        wdog;
    logic [ITER_W-1:0]      iters_tgt;
    logic [ITER_W-1:0]      iter_cnt;
    logic [SQ_OUT_BITS-1:0] last_sq;

    // A zero-iteration job returns the initial value in coefficient form: one word per 32-bit slot.
    function automatic logic [SQ_OUT_BITS-1:0] spread(input logic [MOD_LEN-1:0] v);
        logic [SQ_OUT_BITS-1:0] r;
        r = '0;
        for (int j = 0; j < NUM_ELEMENTS - 2; j++)
            r[32*j +: 32] = {{(32-WORD_LEN){1'b0}}, v[WORD_LEN*j +: WORD_LEN]};
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the wide datapath registers are reset too, so res_sq_out reads 0 after reset
            // rather than a stale result from an interrupted job.
            state          <= IDLE;
            job_ready      <= 1'b1;
            sq_reset       <= 1'b1;
            sq_start       <= 1'b0;
            sq_in          <= '0;
            res_valid      <= 1'b0;
            res_sq_out     <= '0;
            res_iters_done <= '0;
            res_timeout    <= 1'b0;
            busy           <= 1'b0;
            phase          <= '0;
            wdog           <= '0;
            iters_tgt      <= '0;
            iter_cnt       <= '0;
            last_sq        <= '0;
        end else if (abort && state != IDLE) begin
            state     <= IDLE;
            job_ready <= 1'b1;
            sq_reset  <= 1'b1;
            sq_start  <= 1'b0;
            res_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (job_valid) begin
                        sq_in     <= job_sq_in;
                        iters_tgt <= job_iters;
                        iter_cnt  <= '0;
                        wdog      <= '0;
                        phase     <= '0;
                        last_sq   <= '0;
                        job_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (job_iters == '0) begin
                            state          <= DONE;
                            res_valid      <= 1'b1;
                            res_sq_out     <= spread(job_sq_in);
                            res_iters_done <= '0;
                            res_timeout    <= 1'b0;
                        end else begin
                            state <= SQRST;
                        end
                    end
                end
                SQRST: begin
                    if (phase == PH_W'(RST_CYCLES - 1)) begin
                        state    <= LOAD;
                        phase    <= '0;
                        sq_reset <= 1'b0;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                LOAD: begin
                    if (phase == PH_W'(SETUP_CYCLES - 1)) begin
                        state    <= START;
                        sq_start <= 1'b1;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                START: begin
                    state    <= RUN;
                    sq_start <= 1'b0;
                end
                RUN: begin
                    if (sq_valid) begin
                        iter_cnt <= iter_cnt + 1'b1;
                        wdog     <= '0;
                        last_sq  <= sq_out;
                        if (iter_cnt + ITER_W'(1) == iters_tgt) begin
                            state          <= DONE;
                            res_valid      <= 1'b1;
                            res_sq_out     <= sq_out;
                            res_iters_done <= iters_tgt;
                            res_timeout    <= 1'b0;
                            sq_reset       <= 1'b1;
                        end
                    end else if (wdog == WD_W'(TIMEOUT - 1)) begin
                        // Watchdog: report how far the squarer got before it stalled.
                        state          <= DONE;
                        res_valid      <= 1'b1;
                        res_sq_out     <= last_sq;
                        res_iters_done <= iter_cnt;
                        res_timeout    <= 1'b1;
                        sq_reset       <= 1'b1;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state     <= IDLE;
                        res_valid <= 1'b0;
                        job_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_modsq_iter_sequencer.sv
// Self-checking bench for modsq_iter_sequencer: table of jobs against a fixed-latency squarer model,
// plus hand sequences for abort, back-to-back jobs and reset mid-run.
module tb_modsq_iter_sequencer;

    localparam int MOD_LEN = 64;
    localparam int NE      = MOD_LEN / 16 + 2;
    localparam int SQB     = NE * 32;
    localparam int ITER_W  = 32;
    localparam int TIMEOUT = 64;

    logic               clk, reset, job_valid, job_ready, abort;
    logic [MOD_LEN-1:0] job_sq_in, sq_in;
    logic [ITER_W-1:0]  job_iters, res_iters_done;
    logic               sq_reset, sq_start, sq_valid, res_valid, res_ready, res_timeout, busy;
    logic [SQB-1:0]     sq_out, res_sq_out;

    modsq_iter_sequencer #(
        .MOD_LEN(MOD_LEN), .WORD_LEN(16), .ITER_W(ITER_W),
        .RST_CYCLES(8), .SETUP_CYCLES(4), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .job_valid(job_valid), .job_ready(job_ready),
        .job_sq_in(job_sq_in), .job_iters(job_iters), .abort(abort),
        .sq_reset(sq_reset), .sq_start(sq_start), .sq_in(sq_in), .sq_out(sq_out),
        .sq_valid(sq_valid), .res_valid(res_valid), .res_ready(res_ready),
        .res_sq_out(res_sq_out), .res_iters_done(res_iters_done),
        .res_timeout(res_timeout), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Squarer model: after start, one valid every 8 cycles, output k is {NE{32'hA500_0000 | k}}.
    int   max_valids = 0;
    logic m_run;
    int   m_cyc, m_k;

    always @(posedge clk) begin
        if (reset || sq_reset) begin
            m_run    <= 1'b0;
            m_cyc    <= 0;
            m_k      <= 0;
            sq_valid <= 1'b0;
            sq_out   <= '0;
        end else begin
            sq_valid <= 1'b0;
            if (sq_start) begin
                m_run <= 1'b1;
                m_cyc <= 0;
            end else if (m_run) begin
                if (m_cyc == 7) begin
                    m_cyc <= 0;
                    if (m_k < max_valids) begin
                        m_k      <= m_k + 1;
                        sq_valid <= 1'b1;
                        sq_out   <= {NE{32'hA500_0000 | 32'(m_k + 1)}};
                    end
                end else begin
                    m_cyc <= m_cyc + 1;
                end
            end
        end
    end

    typedef struct {
        logic [MOD_LEN-1:0] sq_in;
        logic [ITER_W-1:0]  iters;
        int                 max_valids;
        int                 hold;
        logic [ITER_W-1:0]  exp_done;
        logic               exp_to;
        logic [SQB-1:0]     exp_sq;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " job_ready"}, job_ready, 1);
        check({tag, " sq_reset"}, sq_reset, 1);
        check({tag, " sq_start"}, sq_start, 0);
        check({tag, " sq_in"}, sq_in, 0);
        check({tag, " res_valid"}, res_valid, 0);
        check({tag, " res_sq_out"}, res_sq_out, 0);
        check({tag, " res_iters_done"}, res_iters_done, 0);
        check({tag, " res_timeout"}, res_timeout, 0);
        check({tag, " busy"}, busy, 0);
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 300; i++) begin
            if (job_ready) return;
            @(negedge clk);
        end
        check("job_ready wait", 0, 1);
    endtask

    task automatic accept(input logic [MOD_LEN-1:0] d, input logic [ITER_W-1:0] t, input int mv);
        wait_ready();
        max_valids = mv;
        job_sq_in  = d;
        job_iters  = t;
        job_valid  = 1'b1;
        @(negedge clk);
        job_valid  = 1'b0;
    endtask

    task automatic wait_sq_valid(input string tag);
        bit seen = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (sq_valid) begin
                seen = 1;
                break;
            end
        end
        check({tag, " sq_valid seen"}, seen, 1);
    endtask

    task automatic run_job(input vec_t v, input string tag);
        int rst_len = 0, setup_len = 0, starts = 0, bad = 0;
        bit got = 0;
        logic [SQB-1:0]    snap_sq;
        logic [ITER_W-1:0] snap_it;
        logic              snap_to;
        accept(v.sq_in, v.iters, v.max_valids);
        for (int c = 0; c < 3000; c++) begin
            if (res_valid) begin
                got = 1;
                break;
            end
            if (sq_start) starts++;
            else if (starts == 0 && !sq_reset) setup_len++;
            else if (starts == 0 && setup_len == 0 && sq_reset) rst_len++;
            @(negedge clk);
        end
        check({tag, " res_valid"}, got, 1);
        if (v.iters != 0) begin
            check({tag, " sq_reset cycles"}, rst_len, 8);
            check({tag, " setup cycles"}, setup_len, 4);
        end
        check({tag, " sq_start pulses"}, starts, (v.iters != 0) ? 1 : 0);
        check({tag, " res_iters_done"}, res_iters_done, v.exp_done);
        check({tag, " res_timeout"}, res_timeout, v.exp_to);
        check({tag, " res_sq_out"}, res_sq_out, v.exp_sq);
        check({tag, " sq_in held"}, sq_in, v.sq_in);
        check({tag, " done job_ready"}, job_ready, 0);
        check({tag, " done sq_reset"}, sq_reset, 1);
        snap_sq = res_sq_out;
        snap_it = res_iters_done;
        snap_to = res_timeout;
        for (int i = 0; i < v.hold; i++) begin
            @(negedge clk);
            if (res_valid !== 1'b1 || res_sq_out !== snap_sq || res_iters_done !== snap_it ||
                res_timeout !== snap_to || job_ready !== 1'b0) bad++;
        end
        check({tag, " hold stable"}, bad, 0);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check({tag, " post res_valid"}, res_valid, 0);
        check({tag, " post job_ready"}, job_ready, 1);
        check({tag, " post busy"}, busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global time limit: got running expected finished");
        $fatal(1);
    end

    initial begin
        int acc = 0, hs = 0, st = 0, ovl = 0, nres = 0;
        bit changed = 0, idle = 0;
        vec_t v2;

        reset = 1'b1; job_valid = 1'b0; job_sq_in = '0; job_iters = '0;
        abort = 1'b0; res_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_reset_state("reset");

        vecs[0] = '{sq_in: 64'd5, iters: 32'd3, max_valids: 100, hold: 20,
                    exp_done: 32'd3, exp_to: 1'b0, exp_sq: {NE{32'hA500_0003}}};
        vecs[1] = '{sq_in: 64'h1_2345, iters: 32'd0, max_valids: 0, hold: 3,
                    exp_done: 32'd0, exp_to: 1'b0, exp_sq: 192'h0000_0001_0000_2345};
        vecs[2] = '{sq_in: 64'hDEAD_BEEF_0123_4567, iters: 32'd0, max_valids: 0, hold: 2,
                    exp_done: 32'd0, exp_to: 1'b0,
                    exp_sq: 192'h0000_DEAD_0000_BEEF_0000_0123_0000_4567};
        vecs[3] = '{sq_in: 64'd7, iters: 32'd1, max_valids: 100, hold: 1,
                    exp_done: 32'd1, exp_to: 1'b0, exp_sq: {NE{32'hA500_0001}}};
        vecs[4] = '{sq_in: 64'd9, iters: 32'd5, max_valids: 2, hold: 2,
                    exp_done: 32'd2, exp_to: 1'b1, exp_sq: {NE{32'hA500_0002}}};
        vecs[5] = '{sq_in: 64'd3, iters: 32'd4, max_valids: 0, hold: 1,
                    exp_done: 32'd0, exp_to: 1'b1, exp_sq: '0};

        for (int i = 0; i < 6; i++) run_job(vecs[i], $sformatf("vec%0d", i));

        // Abort one cycle after the first completed squaring.
        accept(64'h11, 32'd5, 100);
        wait_sq_valid("abort");
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort busy", busy, 0);
        check("abort job_ready", job_ready, 1);
        check("abort sq_reset", sq_reset, 1);
        check("abort sq_start", sq_start, 0);
        check("abort res_valid", res_valid, 0);
        repeat (30) begin
            @(negedge clk);
            if (res_valid) nres++;
        end
        check("abort no result", nres, 0);
        v2 = '{sq_in: 64'h44, iters: 32'd2, max_valids: 100, hold: 1,
               exp_done: 32'd2, exp_to: 1'b0, exp_sq: {NE{32'hA500_0002}}};
        run_job(v2, "after abort");

        // job_valid held high: the second job waits until the first result is consumed.
        max_valids = 100;
        job_sq_in  = 64'hAAAA;
        job_iters  = 32'd1;
        res_ready  = 1'b1;
        job_valid  = 1'b1;
        for (int i = 0; i < 400 && acc < 2; i++) begin
            if (job_ready && busy) ovl++;
            if (res_valid && res_ready) hs++;
            if (sq_start) st++;
            if (job_valid && job_ready) begin
                acc++;
                if (acc == 2) begin
                    check("b2b results before 2nd accept", hs, 1);
                    check("b2b starts before 2nd accept", st, 1);
                    check("b2b sq_in of job 1", sq_in, 64'hAAAA);
                end
            end
            @(negedge clk);
            if (acc == 1 && !changed) begin
                job_sq_in = 64'hBBBB;
                changed   = 1;
            end
        end
        job_valid = 1'b0;
        check("b2b accepts", acc, 2);
        check("b2b sq_in of job 2", sq_in, 64'hBBBB);
        check("b2b ready while busy", ovl, 0);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!busy) begin
                idle = 1;
                break;
            end
        end
        check("b2b job 2 finished", idle, 1);
        res_ready = 1'b0;

        // Reset in the middle of RUN behaves like power-on reset.
        accept(64'h22, 32'd3, 100);
        wait_sq_valid("midrun");
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_reset_state("midrun reset");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
